// File: rtl/jtag_axi_dispatch_if.sv
// Command/response bus between the JTAG dispatcher and the AXI-side async FIFO.
interface jtag_axi_dispatch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic              cmd_valid_o;
   logic              cmd_ready_i;
   logic [ADDR_W-1:0] cmd_addr_o;
   logic [DATA_W-1:0] cmd_data_o;
   logic              cmd_wr_o;
   logic [2:0]        cmd_size_o;
   logic              rsp_valid_i;
   logic              rsp_ready_o;
   logic [DATA_W-1:0] rsp_data_i;
   logic [1:0]        rsp_resp_i;

   modport master (
      output cmd_valid_o, cmd_addr_o, cmd_data_o, cmd_wr_o, cmd_size_o, rsp_ready_o,
      input  cmd_ready_i, rsp_valid_i, rsp_data_i, rsp_resp_i
   );

   modport slave (
      input  cmd_valid_o, cmd_addr_o, cmd_data_o, cmd_wr_o, cmd_size_o, rsp_ready_o,
      output cmd_ready_i, rsp_valid_i, rsp_data_i, rsp_resp_i
   );
endinterface

// File: rtl/jtag_axi_dispatch.sv
// Queues JTAG DR requests and issues them one at a time as AXI commands, reporting status.
// Define JTAG_AXI_TIMEOUT_EN to add the response timeout and stale-response absorber.
module jtag_axi_dispatch #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int QDEPTH      = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                    tck,
   input  logic                    trstn,
   input  logic                    req_new_i,
   input  logic [ADDR_W-1:0]       req_addr_i,
   input  logic [DATA_W-1:0]       req_data_i,
   input  logic                    req_wr_i,
   input  logic [2:0]              req_size_i,
   jtag_axi_dispatch_if.master     bus,
   input  logic                    status_rd_i,
   output logic [2:0]              status_code_o,
   output logic [DATA_W-1:0]       status_data_o,
   output logic [$clog2(QDEPTH):0] q_level_o,
   output logic                    busy_o
);
   localparam int AW = $clog2(QDEPTH);
   localparam int LW = AW + 1;
   localparam int PW = ADDR_W + DATA_W + 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   localparam logic [2:0] CODE_IDLE     = 3'd0;
   localparam logic [2:0] CODE_PENDING  = 3'd1;
   localparam logic [2:0] CODE_OK       = 3'd2;
   localparam logic [2:0] CODE_SLVERR   = 3'd3;
   localparam logic [2:0] CODE_DECERR   = 3'd4;
   localparam logic [2:0] CODE_TIMEOUT  = 3'd5;
   localparam logic [2:0] CODE_OVERFLOW = 3'd6;

   state_t            state_q, state_d;
   logic [PW-1:0]     fifo_q [QDEPTH];
   logic [LW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0] cmd_data_q, cmd_data_d, status_data_q, status_data_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [2:0]        cmd_size_q, cmd_size_d, status_code_q, status_code_d, fsm_code_s;
   logic              cmd_valid_q, cmd_valid_d, rsp_ready_q, rsp_ready_d, busy_q, busy_d;
   logic              empty_s, full_s, push_s, pop_s, ovf_s, rsp_hs_s, fsm_upd_s;
   logic              stale_hit_s, timeout_s, stale_pend_s;
   logic [PW-1:0]     head_s;

   assign empty_s  = (wr_ptr_q == rd_ptr_q);
   assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_s    = (state_q == ST_IDLE) && !empty_s;
   // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
   assign push_s   = req_new_i && (!full_s || pop_s);
   assign ovf_s    = req_new_i && full_s && !pop_s;
   assign head_s   = fifo_q[rd_ptr_q[AW-1:0]];
   assign rsp_hs_s = bus.rsp_valid_i && rsp_ready_q;

`ifdef JTAG_AXI_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [3:0]    stale_q, stale_d;

   // responses arrive in order, so while stale is non-zero the next one belongs to a timed-out command
   assign stale_hit_s  = (stale_q != 4'd0);
   assign timeout_s    = (state_q == ST_WAIT_RSP) && (to_cnt_q == TW'(TIMEOUT_CYC - 1)) &&
                         !(rsp_hs_s && !stale_hit_s);
   assign stale_pend_s = (stale_d != 4'd0);

   // wait-cycle counter and saturating stale-response count
   always_comb begin
      to_cnt_d = {TW{1'b0}};
      stale_d  = stale_q;
      if ((state_q == ST_WAIT_RSP) && (state_d == ST_WAIT_RSP)) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end else begin
         to_cnt_d = {TW{1'b0}};
      end
      if (timeout_s && !(rsp_hs_s && stale_hit_s)) begin
         stale_d = (stale_q == 4'hF) ? stale_q : stale_q + 4'd1;
      end else if (!timeout_s && rsp_hs_s && stale_hit_s) begin
         stale_d = stale_q - 4'd1;
      end else begin
         stale_d = stale_q;
      end
   end

   // timeout registers
   always_ff @(posedge tck or negedge trstn) begin
      if (!trstn) begin
         to_cnt_q <= {TW{1'b0}};
         stale_q  <= 4'd0;
      end else begin
         to_cnt_q <= to_cnt_d;
         stale_q  <= stale_d;
      end
   end
`else
   assign stale_hit_s  = 1'b0;
   assign timeout_s    = 1'b0;
   assign stale_pend_s = 1'b0;
`endif

   // transaction FSM: next state, command register load and response decode
   always_comb begin
      state_d       = state_q;
      cmd_addr_d    = cmd_addr_q;
      cmd_data_d    = cmd_data_q;
      cmd_wr_d      = cmd_wr_q;
      cmd_size_d    = cmd_size_q;
      status_data_d = status_data_q;
      fsm_upd_s     = 1'b0;
      fsm_code_s    = CODE_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (pop_s) begin
               {cmd_addr_d, cmd_data_d, cmd_wr_d, cmd_size_d} = head_s;
               fsm_upd_s  = 1'b1;
               fsm_code_s = CODE_PENDING;
               state_d    = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (bus.cmd_ready_i) begin
               state_d = ST_WAIT_RSP;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT_RSP: begin
            if (rsp_hs_s && !stale_hit_s) begin
               fsm_upd_s = 1'b1;
               state_d   = ST_DONE;
               case (bus.rsp_resp_i)
                  2'b00, 2'b01: fsm_code_s = CODE_OK;
                  2'b10:        fsm_code_s = CODE_SLVERR;
                  2'b11:        fsm_code_s = CODE_DECERR;
                  default:      fsm_code_s = CODE_DECERR;
               endcase
               if (!cmd_wr_q) begin
                  status_data_d = bus.rsp_data_i;
               end else begin
                  status_data_d = status_data_q;
               end
            end else if (timeout_s) begin
               fsm_upd_s  = 1'b1;
               fsm_code_s = CODE_TIMEOUT;
               state_d    = ST_DONE;
            end else begin
               state_d = ST_WAIT_RSP;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FIFO pointers, status-code priority and next values of the registered outputs
   always_comb begin
      wr_ptr_d = push_s ? wr_ptr_q + LW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + LW'(1) : rd_ptr_q;
      level_d  = wr_ptr_d - rd_ptr_d;
      if (ovf_s) begin
         status_code_d = CODE_OVERFLOW;
      end else if (fsm_upd_s) begin
         status_code_d = fsm_code_s;
      end else if (status_rd_i) begin
         status_code_d = CODE_IDLE;
      end else begin
         status_code_d = status_code_q;
      end
      cmd_valid_d = (state_d == ST_ISSUE);
      rsp_ready_d = (state_d == ST_WAIT_RSP) || stale_pend_s;
      busy_d      = (state_d != ST_IDLE) || (level_d != {LW{1'b0}});
   end

   // state and output registers
   always_ff @(posedge tck or negedge trstn) begin
      if (!trstn) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= {LW{1'b0}};
         rd_ptr_q      <= {LW{1'b0}};
         level_q       <= {LW{1'b0}};
         cmd_addr_q    <= {ADDR_W{1'b0}};
         cmd_data_q    <= {DATA_W{1'b0}};
         cmd_wr_q      <= 1'b0;
         cmd_size_q    <= 3'd0;
         cmd_valid_q   <= 1'b0;
         rsp_ready_q   <= 1'b0;
         busy_q        <= 1'b0;
         status_code_q <= CODE_IDLE;
         status_data_q <= {DATA_W{1'b0}};
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_data_q    <= cmd_data_d;
         cmd_wr_q      <= cmd_wr_d;
         cmd_size_q    <= cmd_size_d;
         cmd_valid_q   <= cmd_valid_d;
         rsp_ready_q   <= rsp_ready_d;
         busy_q        <= busy_d;
         status_code_q <= status_code_d;
         status_data_q <= status_data_d;
      end
   end

   // FIFO storage; occupancy lives in the pointers, so the array itself needs no reset
   always_ff @(posedge tck) begin
      if (push_s) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= {req_addr_i, req_data_i, req_wr_i, req_size_i};
      end
   end

   assign bus.cmd_valid_o = cmd_valid_q;
   assign bus.cmd_addr_o  = cmd_addr_q;
   assign bus.cmd_data_o  = cmd_data_q;
   assign bus.cmd_wr_o    = cmd_wr_q;
   assign bus.cmd_size_o  = cmd_size_q;
   assign bus.rsp_ready_o = rsp_ready_q;
   assign status_code_o   = status_code_q;
   assign status_data_o   = status_data_q;
   assign q_level_o       = level_q;
   assign busy_o          = busy_q;
endmodule

// File: tb/tb_jtag_axi_dispatch.sv
// Directed bench for jtag_axi_dispatch with a command scoreboard; timeout steps run when JTAG_AXI_TIMEOUT_EN is defined.
module tb_jtag_axi_dispatch;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int QD = 4;
   localparam int TO = 8;

   logic              tck = 1'b0;
   logic              trstn = 1'b0;
   logic              req_new_i = 1'b0;
   logic [AW-1:0]     req_addr_i = '0;
   logic [DW-1:0]     req_data_i = '0;
   logic              req_wr_i = 1'b0;
   logic [2:0]        req_size_i = 3'd0;
   logic              status_rd_i = 1'b0;
   logic [2:0]        status_code_o;
   logic [DW-1:0]     status_data_o;
   logic [$clog2(QD):0] q_level_o;
   logic              busy_o;

   int total = 0;
   int bad = 0;
   logic [AW+DW+3:0] exp_cmd_q [$];

   jtag_axi_dispatch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   jtag_axi_dispatch #(.ADDR_W(AW), .DATA_W(DW), .QDEPTH(QD), .TIMEOUT_CYC(TO)) dut (
      .tck           (tck),
      .trstn         (trstn),
      .req_new_i     (req_new_i),
      .req_addr_i    (req_addr_i),
      .req_data_i    (req_data_i),
      .req_wr_i      (req_wr_i),
      .req_size_i    (req_size_i),
      .bus           (bus),
      .status_rd_i   (status_rd_i),
      .status_code_o (status_code_o),
      .status_data_o (status_data_o),
      .q_level_o     (q_level_o),
      .busy_o        (busy_o)
   );

   always #5 tck = ~tck;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge tck);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [2:0] s, input logic keep);
      req_addr_i = a;
      req_data_i = d;
      req_wr_i   = w;
      req_size_i = s;
      req_new_i  = 1'b1;
      if (keep) exp_cmd_q.push_back({a, d, w, s});
      step();
      req_new_i = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic [1:0] r, input logic rd);
      int n;
      n = 0;
      while ((bus.rsp_ready_o !== 1'b1) && (n < 40)) begin
         step();
         n++;
      end
      check("rsp_ready_seen", 128'(bus.rsp_ready_o), 128'h1);
      bus.rsp_valid_i = 1'b1;
      bus.rsp_data_i  = d;
      bus.rsp_resp_i  = r;
      status_rd_i     = rd;
      step();
      bus.rsp_valid_i = 1'b0;
      status_rd_i     = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_o !== 1'b0) && (n < 40)) begin
         step();
         n++;
      end
      check("idle_reached", 128'(busy_o), 128'h0);
   endtask

   task automatic check_zero_outs(input string pfx);
      check({pfx, "_cmd_valid"}, 128'(bus.cmd_valid_o), 128'h0);
      check({pfx, "_cmd_addr"},  128'(bus.cmd_addr_o),  128'h0);
      check({pfx, "_rsp_ready"}, 128'(bus.rsp_ready_o), 128'h0);
      check({pfx, "_code"},      128'(status_code_o),   128'h0);
      check({pfx, "_data"},      128'(status_data_o),   128'h0);
      check({pfx, "_level"},     128'(q_level_o),       128'h0);
      check({pfx, "_busy"},      128'(busy_o),          128'h0);
   endtask

   // command scoreboard: every accepted command must match the oldest expected request
   always @(negedge tck) begin
      if (trstn && bus.cmd_valid_o && bus.cmd_ready_i) begin
         check("cmd_sb_nonempty", 128'(exp_cmd_q.size() != 0), 128'h1);
         if (exp_cmd_q.size() != 0) begin
            check("cmd_payload", 128'({bus.cmd_addr_o, bus.cmd_data_o, bus.cmd_wr_o, bus.cmd_size_o}),
                  128'(exp_cmd_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_ready_i = 1'b1;
      bus.rsp_valid_i = 1'b0;
      bus.rsp_data_i  = '0;
      bus.rsp_resp_i  = 2'b00;
      repeat (3) step();
      check_zero_outs("rst");
      trstn = 1'b1;
      step();

      // single read: PENDING while in flight, OKAY with captured data afterwards
      send(32'h0000_1000, 32'h0, 1'b0, 3'd2, 1'b1);
      check("rd_level_push", 128'(q_level_o), 128'h1);
      check("rd_busy", 128'(busy_o), 128'h1);
      step();
      check("rd_cmd_valid", 128'(bus.cmd_valid_o), 128'h1);
      check("rd_code_pending", 128'(status_code_o), 128'h1);
      check("rd_level_pop", 128'(q_level_o), 128'h0);
      step();
      check("rd_wait_rsp_ready", 128'(bus.rsp_ready_o), 128'h1);
      check("rd_wait_cmd_valid", 128'(bus.cmd_valid_o), 128'h0);
      step();
      respond(32'hDEAD_BEEF, 2'b00, 1'b0);
      check("rd_code_ok", 128'(status_code_o), 128'h2);
      check("rd_data", 128'(status_data_o), 128'hDEAD_BEEF);
      check("rd_rsp_ready_done", 128'(bus.rsp_ready_o), 128'h0);
      step();
      check("rd_busy_end", 128'(busy_o), 128'h0);

      // write with SLVERR keeps the previous read data
      send(32'h0000_2004, 32'h1234_5678, 1'b1, 3'd2, 1'b1);
      respond(32'hAAAA_5555, 2'b10, 1'b0);
      check("wr_code_slverr", 128'(status_code_o), 128'h3);
      check("wr_data_held", 128'(status_data_o), 128'hDEAD_BEEF);

      // status read coinciding with a DECERR response: the response code wins
      send(32'h0000_3000, 32'h0, 1'b0, 3'd1, 1'b1);
      respond(32'h0BAD_F00D, 2'b11, 1'b1);
      check("rdclr_code_decerr", 128'(status_code_o), 128'h4);
      check("rdclr_data", 128'(status_data_o), 128'h0BAD_F00D);
      status_rd_i = 1'b1;
      step();
      status_rd_i = 1'b0;
      check("rdclr_code_idle", 128'(status_code_o), 128'h0);

      // back-to-back burst with the command side stalled: one in ISSUE, four queued,
      // and only the sixth pulse finds the FIFO full
      wait_idle();
      bus.cmd_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(32'h0000_0100 + 32'(i * 16), 32'hA000_0000 + 32'(i), 1'(i % 2), 3'd2, (i < 5));
         if (i == 4) begin
            check("ovf_level_full", 128'(q_level_o), 128'h4);
            check("ovf_code_before", 128'(status_code_o), 128'h1);
         end
      end
      check("ovf_level_after", 128'(q_level_o), 128'h4);
      check("ovf_code", 128'(status_code_o), 128'h6);
      check("ovf_cmd_stable", 128'(bus.cmd_addr_o), 128'h100);
      check("ovf_cmd_valid", 128'(bus.cmd_valid_o), 128'h1);

      // drain one, then push on the same edge the full FIFO is popped
      bus.cmd_ready_i = 1'b1;
      respond(32'h5555_0000, 2'b01, 1'b0);
      check("drain_code_ok", 128'(status_code_o), 128'h2);
      check("drain_data", 128'(status_data_o), 128'h5555_0000);
      step();
      send(32'h0000_0900, 32'hB0B0_B0B0, 1'b0, 3'd2, 1'b1);
      check("pushpop_level", 128'(q_level_o), 128'h4);
      check("pushpop_code", 128'(status_code_o), 128'h1);
      check("pushpop_cmd_addr", 128'(bus.cmd_addr_o), 128'h110);
      step();
      check("midrst_in_wait", 128'(bus.rsp_ready_o), 128'h1);

      // asynchronous reset in WAIT_RSP abandons everything
      #2 trstn = 1'b0;
      #1;
      check_zero_outs("midrst");
      exp_cmd_q.delete();
      repeat (3) step();
      trstn = 1'b1;
      step();
      step();
      check("postrst_cmd_valid", 128'(bus.cmd_valid_o), 128'h0);
      check("postrst_busy", 128'(busy_o), 128'h0);
      send(32'h0000_4000, 32'h0, 1'b0, 3'd2, 1'b1);
      respond(32'h1122_3344, 2'b00, 1'b0);
      check("postrst_code", 128'(status_code_o), 128'h2);
      check("postrst_data", 128'(status_data_o), 128'h1122_3344);
      wait_idle();

`ifdef JTAG_AXI_TIMEOUT_EN
      begin
         int n;
         send(32'h0000_5000, 32'h0, 1'b0, 3'd2, 1'b1);
         n = 0;
         while ((bus.rsp_ready_o !== 1'b1) && (n < 10)) begin
            step();
            n++;
         end
         check("to_enter_wait", 128'(bus.rsp_ready_o), 128'h1);
         n = 0;
         while ((status_code_o !== 3'd5) && (n < 20)) begin
            step();
            n++;
         end
         check("to_wait_cycles", 128'(n), 128'(TO));
         check("to_code", 128'(status_code_o), 128'h5);
         step();
         check("to_stale_ready", 128'(bus.rsp_ready_o), 128'h1);
         respond(32'hBAD0_BAD0, 2'b00, 1'b0);
         check("to_late_code", 128'(status_code_o), 128'h5);
         check("to_late_data", 128'(status_data_o), 128'h1122_3344);
         step();
         check("to_stale_clear", 128'(bus.rsp_ready_o), 128'h0);
         send(32'h0000_6000, 32'h0, 1'b0, 3'd2, 1'b1);
         respond(32'hCAFE_F00D, 2'b00, 1'b0);
         check("to_next_code", 128'(status_code_o), 128'h2);
         check("to_next_data", 128'(status_data_o), 128'hCAFE_F00D);
         wait_idle();
      end
`endif

      check("sb_drained", 128'(exp_cmd_q.size()), 128'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
